pixel_write_sink: RTL

Receiving end of the plot interface. Accepts pixel plot requests (x, y, colour, plot strobe) from the plotting logic, buffers them in a small FIFO, and bounds-checks each one. Converts accepted coordinates to linear framebuffer addresses and drives the VGA framebuffer write port. Also performs a full-screen clear sweep on request, so plotters no longer need their own reset-drawing path.

---
 rtl/pixel_pkg.sv | 30 +++
 rtl/pixel_fifo.sv | 52 +++++
 rtl/pixel_write_sink.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// Shared widths, screen geometry, FSM state and FIFO entry layout for the pixel write sink.
package pixel_pkg;

  localparam int unsigned X_W       = 8;
  localparam int unsigned Y_W       = 7;
  localparam int unsigned C_W       = 3;
  localparam int unsigned SCREEN_W  = 160;
  localparam int unsigned SCREEN_H  = 120;
  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned LAST_ADDR = SCREEN_W * SCREEN_H - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
  } pixel_t;

  // y*160 + x as shifts; the 15-bit result holds the largest address (19199)
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO of pixel entries with a synchronous flush.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush_i,
  input  logic   push_i,
  input  logic   pop_i,
  input  pixel_t din_i,
  output pixel_t dout_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  pixel_t           mem_q [DEPTH];
  logic [PTR_W:0]   wr_q;
  logic [PTR_W:0]   rd_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers carry one extra wrap bit to tell full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (PTR_W+1)'(1);
      if (do_pop)  rd_q <= rd_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PTR_W-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_q[PTR_W-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                   (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);

endmodule

// File: rtl/pixel_write_sink.sv
// Buffers plot requests, clips them to the screen and drives the framebuffer write port;
// also sweeps the whole screen to BG_COLOUR on clear_req. Define CLIP_COUNT_EN for clip_count.
module pixel_write_sink
  import pixel_pkg::*;
#(
  parameter int unsigned   DEPTH     = 4,
  parameter logic [C_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              plot,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [C_W-1:0]    colour,
  output logic              ready,
  input  logic              clear_req,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [C_W-1:0]    mem_data,
  output logic              busy
`ifdef CLIP_COUNT_EN
  ,
  output logic [7:0]        clip_count
`endif
);

  state_e              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [C_W-1:0]      mem_data_q, mem_data_d;
  logic                busy_q, busy_d;

  logic   in_range;
  logic   accept;
  logic   fifo_push;
  logic   fifo_pop;
  logic   fifo_flush;
  logic   fifo_full;
  logic   fifo_empty;
  pixel_t fifo_din;
  pixel_t fifo_dout;

  assign ready     = resetn && (state_q != CLEAR) && !fifo_full && !clear_req;
  assign in_range  = (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
  assign accept    = plot && ready;
  assign fifo_push = accept && in_range;
  assign fifo_din  = '{x: x, y: y, colour: colour};

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    busy_d     = busy_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      IDLE, DRAIN: begin
        if (clear_req) begin
          // Queued and stalled pixels are discarded; the sweep owns the port
          fifo_flush = 1'b1;
          state_d    = CLEAR;
          mem_we_d   = 1'b1;
          mem_addr_d = '0;
          mem_data_d = BG_COLOUR;
          busy_d     = 1'b1;
        end else begin
          if (!fifo_empty && (!mem_we_q || mem_ready)) begin
            fifo_pop   = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = pixel_addr(fifo_dout.x, fifo_dout.y);
            mem_data_d = fifo_dout.colour;
          end else if (mem_we_q && mem_ready) begin
            mem_we_d = 1'b0;
          end
          if (fifo_push) begin
            state_d = DRAIN;
          end else if ((state_q == DRAIN) && fifo_empty && !mem_we_q) begin
            state_d = IDLE;
          end
        end
      end
      CLEAR: begin
        mem_we_d = 1'b1;
        if (mem_ready) begin
          if (mem_addr_q == ADDR_W'(LAST_ADDR)) begin
            state_d  = IDLE;
            mem_we_d = 1'b0;
            busy_d   = 1'b0;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign busy     = busy_q;

`ifdef CLIP_COUNT_EN
  logic [7:0] clip_q;

  // Rejected out-of-range requests, saturating at 255
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clip_q <= '0;
    end else if (accept && !in_range && (clip_q != 8'hFF)) begin
      clip_q <= clip_q + 8'd1;
    end
  end

  assign clip_count = clip_q;
`endif

endmodule
